// File: rtl/div_fmt_pkg.sv
// Shared types and constants for the divider result BCD formatter.
package div_fmt_pkg;
    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    localparam int unsigned W_DEF          = 16;
    localparam int unsigned DIGITS_DEF     = 5;
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;
endpackage

// File: rtl/bcd_dabble_lane.sv
// One shift-add-3 conversion lane: binary shift register plus packed BCD accumulator.
module bcd_dabble_lane
    import div_fmt_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [W-1:0]          din,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [W-1:0]        bin;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;

    // Each nibble is adjusted independently; the +3 wraps within 4 bits.
    always_comb begin
        adj = acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'(BCD_ADJ_THRESH))
                adj[4*d +: 4] = acc[4*d +: 4] + 4'(BCD_ADJ_ADD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin <= '0;
            acc <= '0;
        end else if (load) begin
            bin <= din;
            acc <= '0;
        end else if (step) begin
            {acc, bin} <= {adj, bin} << 1;
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/div_bcd_formatter.sv
// Captures divider quotient/remainder, converts both to packed BCD and hands them
// to a valid/ready sink, with a one-entry pending buffer for results arriving while busy.
module div_bcd_formatter
    import div_fmt_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          qt,
    input  logic [W-1:0]          rm,
    input  logic                  ordy,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  ovf_err
);

    localparam int unsigned CW = $clog2(W);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           pending_v;
    logic [W-1:0]   pend_q, pend_r;

    logic           lane_load, lane_step, use_pend;
    logic           pend_wr, pend_clr, ovf_set;
    logic [W-1:0]   q_din, r_din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // In HOLD with a handshake, a buffered result always goes first; a new ordy
    // then refills the buffer instead of raising an error.
    always_comb begin
        state_nxt = state;
        lane_load = 1'b0;
        lane_step = 1'b0;
        use_pend  = 1'b0;
        pend_wr   = 1'b0;
        pend_clr  = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            IDLE: begin
                if (ordy) begin
                    lane_load = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                lane_step = 1'b1;
                if (cnt == '0) state_nxt = HOLD;
                if (ordy) begin
                    if (pending_v) ovf_set = 1'b1;
                    else           pend_wr = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (pending_v) begin
                        lane_load = 1'b1;
                        use_pend  = 1'b1;
                        state_nxt = CONV;
                        if (ordy) pend_wr  = 1'b1;
                        else      pend_clr = 1'b1;
                    end else if (ordy) begin
                        lane_load = 1'b1;
                        state_nxt = CONV;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (ordy) begin
                    if (pending_v) ovf_set = 1'b1;
                    else           pend_wr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_valid = (state == HOLD);
        busy      = (state != IDLE) || pending_v;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            pending_v <= 1'b0;
            pend_q    <= '0;
            pend_r    <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (lane_load)
                cnt <= CW'(W - 1);
            else if (lane_step && cnt != '0)
                cnt <= cnt - 1'b1;

            if (pend_wr) begin
                pend_q    <= qt;
                pend_r    <= rm;
                pending_v <= 1'b1;
            end else if (pend_clr) begin
                pending_v <= 1'b0;
            end

            if (ovf_set)      ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;
        end
    end

    assign q_din = use_pend ? pend_q : qt;
    assign r_din = use_pend ? pend_r : rm;

    bcd_dabble_lane #(.W(W), .DIGITS(DIGITS)) u_lane_q (
        .clk   (clk),
        .reset (reset),
        .load  (lane_load),
        .step  (lane_step),
        .din   (q_din),
        .bcd   (q_bcd)
    );

    bcd_dabble_lane #(.W(W), .DIGITS(DIGITS)) u_lane_r (
        .clk   (clk),
        .reset (reset),
        .load  (lane_load),
        .step  (lane_step),
        .din   (r_din),
        .bcd   (r_bcd)
    );

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Directed bench for div_bcd_formatter with hand-computed BCD results.
module tb_div_bcd_formatter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] qt = '0;
    logic [15:0] rm = '0;
    logic        ordy = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [19:0] q_bcd, r_bcd;
    logic        bcd_valid, busy, ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_bcd_formatter #(.W(16), .DIGITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .qt        (qt),
        .rm        (rm),
        .ordy      (ordy),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .ovf_err   (ovf_err)
    );

    // Drive a one-cycle ordy pulse; returns 1 time unit after the capture edge.
    task automatic send(input logic [15:0] q, input logic [15:0] r);
        @(negedge clk);
        qt = q; rm = r; ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    // Waits (bounded) for bcd_valid, sampling 1 time unit after each edge.
    task automatic wait_valid(input int max_cyc, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (bcd_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({bcd_valid, busy, ovf_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/busy/ovf=%b required 000", {bcd_valid, busy, ovf_err});
        end
        n_checks++;
        if ({q_bcd, r_bcd} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_bcd: got q=%h r=%h required 00000 00000", q_bcd, r_bcd);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int cyc; bit ok;
        out_ready = 1'b1;
        send(16'd12345, 16'd678);
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 16) begin
            n_fail++;
            $display("FAIL basic_latency: got ok=%0d cycles=%0d required cycles=16", ok, cyc);
        end
        n_checks++;
        if (q_bcd !== 20'h12345 || r_bcd !== 20'h00678) begin
            n_fail++;
            $display("FAIL basic_value: got q=%h r=%h required 12345 00678", q_bcd, r_bcd);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got valid=%b busy=%b required 0 0", bcd_valid, busy);
        end
    endtask

    task automatic test_extremes;
        int cyc; bit ok;
        out_ready = 1'b1;
        send(16'd65535, 16'd0);
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || q_bcd !== 20'h65535 || r_bcd !== 20'h00000) begin
            n_fail++;
            $display("FAIL extreme_max: got ok=%0d q=%h r=%h required 65535 00000", ok, q_bcd, r_bcd);
        end
        @(posedge clk); #1;
        send(16'd0, 16'd9);
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || q_bcd !== 20'h00000 || r_bcd !== 20'h00009) begin
            n_fail++;
            $display("FAIL extreme_zero: got ok=%0d q=%h r=%h required 00000 00009", ok, q_bcd, r_bcd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int cyc; bit ok; bit stable;
        out_ready = 1'b0;
        send(16'd100, 16'd0);
        wait_valid(40, cyc, ok);
        repeat (3) @(posedge clk);
        send(16'd200, 16'd0);
        stable = ok;
        for (int i = 0; i < 6; i++) begin
            if (bcd_valid !== 1'b1 || q_bcd !== 20'h00100) stable = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_hold_stable: got valid=%b q=%h required 1 00100 held", bcd_valid, q_bcd);
        end
        n_checks++;
        if (busy !== 1'b1 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_flags: got busy=%b ovf=%b required 1 0", busy, ovf_err);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 16 || q_bcd !== 20'h00200) begin
            n_fail++;
            $display("FAIL bp_second: got ok=%0d cycles=%0d q=%h required 16 00200", ok, cyc, q_bcd);
        end
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_ovf: got ovf=%b required 0", ovf_err);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_overflow;
        int cyc; bit ok;
        out_ready = 1'b0;
        send(16'd1, 16'd0);
        send(16'd2, 16'd0);
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: got ovf=%b required 0", ovf_err);
        end
        send(16'd3, 16'd0);
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%b required 1", ovf_err);
        end
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || q_bcd !== 20'h00001) begin
            n_fail++;
            $display("FAIL ovf_first: got ok=%0d q=%h required 00001", ok, q_bcd);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || q_bcd !== 20'h00002 || ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_second: got ok=%0d q=%h ovf=%b required 00002 1", ok, q_bcd, ovf_err);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_dropped: got busy=%b required 0", busy);
        end
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got ovf=%b required 0", ovf_err);
        end
    endtask

    task automatic test_ordy_held;
        int cyc; bit ok;
        out_ready = 1'b1;
        @(negedge clk);
        qt = 16'd7; rm = 16'd3; ordy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0; err_clr = 1'b0;
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL held_set_dominant: got ovf=%b required 1", ovf_err);
        end
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || q_bcd !== 20'h00007 || r_bcd !== 20'h00003) begin
            n_fail++;
            $display("FAIL held_first: got ok=%0d q=%h r=%h required 00007 00003", ok, q_bcd, r_bcd);
        end
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 17 || q_bcd !== 20'h00007) begin
            n_fail++;
            $display("FAIL held_second: got ok=%0d cycles=%0d q=%h required 17 00007", ok, cyc, q_bcd);
        end
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_drain: got busy=%b required 0", busy);
        end
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc; bit ok;
        out_ready = 1'b0;
        send(16'd4321, 16'd55);
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || q_bcd !== 20'h04321 || r_bcd !== 20'h00055) begin
            n_fail++;
            $display("FAIL b2b_first: got ok=%0d q=%h r=%h required 04321 00055", ok, q_bcd, r_bcd);
        end
        qt = 16'd999; rm = 16'd12; ordy = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (bcd_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_direct: got valid=%b busy=%b required 0 1", bcd_valid, busy);
        end
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 16 || q_bcd !== 20'h00999 || r_bcd !== 20'h00012) begin
            n_fail++;
            $display("FAIL b2b_second: got ok=%0d cycles=%0d q=%h r=%h required 16 00999 00012", ok, cyc, q_bcd, r_bcd);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_pending: got busy=%b ovf=%b required 0 0", busy, ovf_err);
        end
    endtask

    task automatic test_reset_mid_conv;
        int cyc; bit ok;
        out_ready = 1'b0;
        send(16'd5555, 16'd44);
        send(16'd1, 16'd0);
        send(16'd2, 16'd0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bcd_valid, busy, ovf_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid: got valid/busy/ovf=%b required 000", {bcd_valid, busy, ovf_err});
        end
        @(negedge clk); reset = 1'b1;
        out_ready = 1'b1;
        send(16'd321, 16'd9);
        wait_valid(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 16 || q_bcd !== 20'h00321 || r_bcd !== 20'h00009) begin
            n_fail++;
            $display("FAIL rst_fresh: got ok=%0d cycles=%0d q=%h r=%h required 16 00321 00009", ok, cyc, q_bcd, r_bcd);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pending_gone: got busy=%b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_overflow();
        test_ordy_held();
        test_back_to_back();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_bcd_formatter.md
Name: div_bcd_formatter

Overview:
- Downstream consumer of the 32/16 non-restoring divider.
- Captures the 16-bit quotient and remainder on the divider's one-cycle ordy pulse.
- Converts both values in parallel to packed BCD using shift-add-3 (double-dabble) over 16 cycles.
- Presents results on a valid/ready handshake, with a one-entry pending buffer so a stalled sink does not lose a result.

Parameters:
- W, 16: binary operand width; must match the divider qt/rm width.
- DIGITS, 5: BCD digits per value; must satisfy 10^DIGITS > 2^W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- qt  in  W  divider quotient; sampled only when ordy=1
- rm  in  W  divider remainder; sampled only when ordy=1
- ordy  in  1  divider result-ready pulse, one cycle wide
- out_ready  in  1  sink can accept a result
- err_clr  in  1  synchronous clear of ovf_err
- q_bcd  out  4*DIGITS  packed BCD quotient, most-significant digit at the top
- r_bcd  out  4*DIGITS  packed BCD remainder
- bcd_valid  out  1  q_bcd/r_bcd valid
- busy  out  1  high when state != IDLE or pending is valid
- ovf_err  out  1  sticky: a result was dropped

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; pending_v=0; iteration counter=0.
  - Shift registers, q_bcd, r_bcd and ovf_err all 0.
  - bcd_valid=0, busy=0.
- States: IDLE, CONV, HOLD.
- IDLE:
  - ordy=1 loads {qt,rm} into the two binary shift registers, clears the BCD accumulators, sets cnt=W-1 and moves to CONV.
  - ordy=0: stay in IDLE.
- CONV, one iteration per clock, applied to each lane independently:
  - Any BCD nibble >= 5 gets +3 (combinational).
  - Then {bcd,bin} shifts left by 1.
  - cnt decrements each clock; at the edge where cnt==0, the final iteration is applied and the state moves to HOLD.
- Latency: ordy sampled at edge E0 -> bcd_valid=1 after edge E0+W (16 clocks); q_bcd/r_bcd are stable from that point.
- HOLD:
  - bcd_valid=1. Outputs and bcd_valid must not change until the handshake (bcd_valid && out_ready).
  - On handshake with pending_v=1: load pending into the lanes, clear pending_v, go to CONV.
  - On handshake with pending_v=0 and ordy=0: go to IDLE.
  - On handshake with pending_v=0 and ordy=1: load the ordy data directly and go to CONV; the result must not pass through pending.
- Outputs: q_bcd/r_bcd are driven from the BCD accumulators. Only the value in HOLD is meaningful.
- ordy arriving while in CONV, or in HOLD without a handshake:
  - pending_v=0: store into pending, set pending_v=1.
  - pending_v=1: drop the new data and set ovf_err=1. Pending keeps the older result.
- ordy with handshake in HOLD and pending_v=1: pending goes to the lanes; the ordy data goes to pending (pending_v stays 1); no error.
- ovf_err:
  - Set-dominant: set and err_clr in the same cycle leaves ovf_err=1.
  - Cleared only by err_clr or reset.
- Arithmetic:
  - Adjust compares each nibble as unsigned >= 5; the +3 is a 4-bit add with no carry out.
  - The BCD accumulator is 4*DIGITS bits and must never overflow for inputs <= 2^W-1.
- ordy held high for more than one cycle: each high cycle counts as a separate result. The divider never does this; the bench checks that the error path fires.
- Reset mid-CONV/HOLD: immediate return to IDLE; pending discarded; bcd_valid drops asynchronously.
- The block does not interpret divider overflow. Truncated qt/rm are formatted as given.

Decomposition:
- Package div_fmt_pkg:
  - state enum {IDLE, CONV, HOLD}
  - constants W_DEF=16, DIGITS_DEF=5, BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3
- Sub-module bcd_dabble_lane (parameters W, DIGITS):
  - Holds the bin/bcd registers for one lane.
  - Inputs: load, step, din. Output: bcd.
  - Instantiated twice: quotient and remainder.
  - All control (FSM, cnt, pending, handshake) lives in the top level.

Test Plan:
- Basic conversion:
  - qt=12345, rm=678, ordy pulse, out_ready=1 -> bcd_valid exactly 16 clocks after the capture edge.
  - q_bcd=20'h12345, r_bcd=20'h00678; then IDLE, busy=0.
- Extremes:
  - qt=65535, rm=0 -> q_bcd=20'h65535, r_bcd=20'h00000.
  - qt=0, rm=9 -> q_bcd=20'h00000, r_bcd=20'h00009.
- Backpressure with pending:
  - out_ready=0; first ordy (qt=100) and second ordy (qt=200) 20 clocks apart.
  - First HOLD shows 20'h00100 and stays stable; raise out_ready -> handshake, then 16 clocks later 20'h00200; ovf_err=0.
- Overflow drop:
  - out_ready=0; three ordy pulses (qt=1,2,3) -> ovf_err=1 after the third.
  - Delivered results are 1 then 2; err_clr -> ovf_err=0.
- Simultaneous handshake + ordy in HOLD, pending empty:
  - Next result is captured directly into CONV; pending_v stays 0; correct BCD 16 clocks later.
- Reset mid-CONV:
  - Assert reset at iteration 8 -> bcd_valid=0, busy=0, ovf_err=0 immediately.
  - A fresh ordy after release converts correctly.
